// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit between execute and the data-memory bus.
//
// Accepts one memory request at a time from execute, issues a single
// outstanding bus transaction, and writes extended load data back to the
// register file. The pc is stalled via hold_o while the transaction runs.
//
// Ports:
//   clk, rst          core clock, synchronous active-low reset
//   mem_re_i/mem_we_i load/store strobes (both high = load)
//   addr_i, wdata_i   byte address and store data
//   byte_sel_i        00 byte, 01 half, 10 word, 11 no access
//   un_sign_i         load zero-extend (1) / sign-extend (0)
//   rd_waddr_i        load destination register
//   bus_*             request side of the data-memory bus, plus gnt/rvalid/rdata
//   rd_we_o/rd_waddr_o/rd_wdata_o  register file write port
//   hold_o            stall request to pc / upstream stages
//   misalign_o        pulse: misaligned request dropped
//   bus_err_o         pulse: transaction abandoned after TIMEOUT cycles
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  byte_sel_i,
    input  logic        un_sign_i,
    input  logic [4:0]  rd_waddr_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic        hold_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             we_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic [4:0]       rd_q;
    logic             err_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      rd_wdata_q;

    logic req_valid;
    logic req_misalign;
    logic accept;
    logic tmo_hit;

    function automatic logic [3:0] lane_be(input logic [1:0] sel, input logic [1:0] off);
        case (sel)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sel, input logic [31:0] data);
        case (sel)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sel, input logic [1:0] off,
                                                input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (sel)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    assign req_valid    = (mem_re_i | mem_we_i) & (byte_sel_i != 2'b11);
    assign req_misalign = ((byte_sel_i == 2'b01) & addr_i[0]) |
                          ((byte_sel_i == 2'b10) & (addr_i[1:0] != 2'b00));
    // Gated by rst so every output reads zero while reset is held.
    assign accept       = rst & (state == S_IDLE) & req_valid & ~req_misalign;
    assign misalign_o   = rst & (state == S_IDLE) & req_valid & req_misalign;
    assign hold_o       = rst & (accept | (state == S_REQ) | (state == S_RWAIT));
    // Counter value is the number of REQ/RWAIT cycles already completed.
    assign tmo_hit      = (tmo_cnt >= TMO_LAST);

    assign bus_req_o   = (state == S_REQ);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;
    assign rd_waddr_o  = rd_q;
    assign rd_wdata_o  = rd_wdata_q;
    assign rd_we_o     = (state == S_DONE) & ~we_q & ~err_q & (rd_q != 5'd0);
    assign bus_err_o   = (state == S_DONE) & err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            uns_q      <= 1'b0;
            rd_q       <= 5'd0;
            err_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            rd_wdata_q <= 32'd0;
        end else begin
            case (state)
                // Capture: bus fields are frozen here for the whole transaction.
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_REQ;
                        tmo_cnt <= '0;
                        err_q   <= 1'b0;
                        we_q    <= ~mem_re_i;
                        size_q  <= byte_sel_i;
                        off_q   <= addr_i[1:0];
                        uns_q   <= un_sign_i;
                        rd_q    <= rd_waddr_i;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        be_q    <= lane_be(byte_sel_i, addr_i[1:0]);
                        wdata_q <= mem_re_i ? 32'd0 : lane_wdata(byte_sel_i, wdata_i);
                    end
                end
                // Request phase: a grant in the final allowed cycle still wins.
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus_gnt_i) begin
                        state <= we_q ? S_DONE : S_RWAIT;
                    end else if (tmo_hit) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end
                end
                // Read data phase.
                S_RWAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus_rvalid_i) begin
                        state      <= S_DONE;
                        rd_wdata_q <= load_extend(size_q, off_q, uns_q, bus_rdata_i);
                    end else if (tmo_hit) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end
                end
                // Writeback / release: the same instruction is still presented, so ignore inputs.
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int TMO = 4;
    localparam int K_BUS = 0;
    localparam int K_RD  = 1;
    localparam int K_MIS = 2;
    localparam int K_ERR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re_i, mem_we_i;
    logic [31:0] addr_i, wdata_i;
    logic [1:0]  byte_sel_i;
    logic        un_sign_i;
    logic [4:0]  rd_waddr_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    logic        hold_o, misalign_o, bus_err_o;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .byte_sel_i(byte_sel_i), .un_sign_i(un_sign_i), .rd_waddr_i(rd_waddr_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
        .hold_o(hold_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Bus responder controls
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    bit          never_gnt = 0;
    bit          noise     = 0;
    logic [31:0] rdata_v   = 32'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    // Reference model: lanes and extension from byte counts and offsets.
    function automatic logic [3:0] m_be(input int n, input int o);
        logic [3:0] be;
        be = 4'd0;
        for (int k = 0; k < 4; k++) if (k >= o && k < o + n) be[k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] d);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input int n, input int o, input bit uns, input logic [31:0] rd);
        longint v;
        longint span;
        span = longint'(1) << (8 * n);
        v = (longint'(rd) >> (8 * o)) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected output: got event kind %0d, expected none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_req"},   bus_req_o,   0);
        check({tag, " bus_we"},    bus_we_o,    0);
        check({tag, " bus_addr"},  bus_addr_o,  0);
        check({tag, " bus_wdata"}, bus_wdata_o, 0);
        check({tag, " bus_be"},    bus_be_o,    0);
        check({tag, " rd_we"},     rd_we_o,     0);
        check({tag, " rd_waddr"},  rd_waddr_o,  0);
        check({tag, " rd_wdata"},  rd_wdata_o,  0);
        check({tag, " hold"},      hold_o,      0);
        check({tag, " misalign"},  misalign_o,  0);
        check({tag, " bus_err"},   bus_err_o,   0);
    endtask

    // Bus responder: drives shortly after each rising edge.
    initial begin
        int  gcnt;
        int  rcnt;
        bit  rd_pend;
        gcnt = 0; rcnt = 0; rd_pend = 0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
            if (rd_pend) begin
                if (rcnt >= rv_delay) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = rdata_v;
                    rd_pend = 0;
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else if (bus_req_o && !never_gnt) begin
                if (gcnt >= gnt_delay) begin
                    bus_gnt_i = 1'b1;
                    gcnt = 0;
                    if (!bus_we_o) rd_pend = 1;
                end else begin
                    gcnt++;
                    // Stray read-valid during the request phase must be ignored.
                    if (noise && $urandom_range(0, 1) == 1) bus_rvalid_i = 1'b1;
                end
            end else if (bus_req_o && noise && $urandom_range(0, 1) == 1) begin
                bus_rvalid_i = 1'b1;
            end
        end
    end

    // Monitor: samples on the falling edge, pops and compares against the scoreboard.
    initial begin
        exp_t        e;
        bit          ok;
        logic        p_req, p_we;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_be;
        p_req = 1'b0; p_we = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_be = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_req = 1'b0;
            end else begin
                if (bus_req_o && p_req) begin
                    check("bus_we stable",    bus_we_o,    p_we);
                    check("bus_addr stable",  bus_addr_o,  p_addr);
                    check("bus_be stable",    bus_be_o,    p_be);
                    check("bus_wdata stable", bus_wdata_o, p_wdata);
                end
                p_req = bus_req_o; p_we = bus_we_o; p_addr = bus_addr_o;
                p_be = bus_be_o; p_wdata = bus_wdata_o;
                if (bus_req_o && bus_gnt_i) begin
                    pop_exp(K_BUS, e, ok);
                    if (ok) begin
                        check("bus_we",    bus_we_o,    e.we);
                        check("bus_addr",  bus_addr_o,  e.addr);
                        check("bus_be",    bus_be_o,    e.be);
                        check("bus_wdata", bus_wdata_o, e.wdata);
                    end
                end
                if (rd_we_o) begin
                    pop_exp(K_RD, e, ok);
                    if (ok) begin
                        check("rd_waddr", rd_waddr_o, e.rd);
                        check("rd_wdata", rd_wdata_o, e.wdata);
                    end
                end
                if (misalign_o) begin
                    pop_exp(K_MIS, e, ok);
                    if (ok) begin
                        check("misalign hold", hold_o, 0);
                        check("misalign bus_req", bus_req_o, 0);
                    end
                end
                if (bus_err_o) begin
                    pop_exp(K_ERR, e, ok);
                    if (ok) begin
                        check("timeout rd_we", rd_we_o, 0);
                        check("timeout bus_req", bus_req_o, 0);
                        check("timeout hold", hold_o, 0);
                    end
                end
            end
        end
    end

    task automatic issue(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] bs, input bit uns, input logic [4:0] rd,
                         input logic [31:0] rdv, input int gd, input int rvd, input string name);
        int   n, o, hc, exp_hc;
        bit   valid, mis;
        exp_t e;
        n = 1 << bs;
        o = int'(a[1:0]);
        valid = (re || we) && bs != 2'b11;
        mis = valid && (int'(a[1:0]) % n != 0);
        exp_hc = 0;
        e = '{default: 0};
        if (valid && mis) begin
            e.kind = K_MIS;
            exp_q.push_back(e);
        end else if (valid) begin
            e.kind  = K_BUS;
            e.we    = !re;
            e.addr  = a & 32'hFFFF_FFFC;
            e.be    = m_be(n, o);
            e.wdata = re ? 32'd0 : m_wdata(n, wd);
            exp_q.push_back(e);
            if (re && rd != 5'd0) begin
                e.kind  = K_RD;
                e.rd    = rd;
                e.wdata = m_load(n, o, uns, rdv);
                exp_q.push_back(e);
            end
            exp_hc = re ? gd + rvd + 3 : gd + 2;
        end
        gnt_delay = gd; rv_delay = rvd; rdata_v = rdv;
        @(posedge clk);
        #2;
        mem_re_i = re; mem_we_i = we; addr_i = a; wdata_i = wd;
        byte_sel_i = bs; un_sign_i = uns; rd_waddr_i = rd;
        hc = 0;
        @(negedge clk);
        while (hold_o && hc < 400) begin
            hc++;
            @(negedge clk);
        end
        check({name, " hold cycles"}, hc, exp_hc);
        @(posedge clk);
        #2;
        mem_re_i = 1'b0; mem_we_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   hc;
        rst = 1'b0;
        mem_re_i = 1'b0; mem_we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
        byte_sel_i = 2'b00; un_sign_i = 1'b0; rd_waddr_i = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Directed stimulus
        issue(0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 5'd0, 32'd0, 2, 0, "sw");
        issue(0, 1, 32'h103, 32'h000000A5, 2'b00, 0, 5'd0, 32'd0, 0, 0, "sb");
        issue(0, 1, 32'h102, 32'h00001234, 2'b01, 0, 5'd0, 32'd0, 1, 0, "sh");
        issue(1, 0, 32'h101, 32'd0, 2'b00, 0, 5'd5, 32'h00008000, 0, 0, "lb");
        issue(1, 0, 32'h101, 32'd0, 2'b00, 1, 5'd5, 32'h00008000, 0, 1, "lbu");
        issue(1, 0, 32'h102, 32'd0, 2'b01, 1, 5'd6, 32'hBEEF0000, 1, 0, "lhu");
        issue(1, 0, 32'h102, 32'd0, 2'b10, 0, 5'd3, 32'd0, 0, 0, "lw misaligned");
        issue(1, 0, 32'h104, 32'd0, 2'b10, 0, 5'd0, 32'h12345678, 0, 0, "lw rd0");
        issue(0, 1, 32'h108, 32'h55AA55AA, 2'b11, 0, 5'd0, 32'd0, 0, 0, "no access");
        issue(1, 1, 32'h10C, 32'hFFFFFFFF, 2'b10, 0, 5'd9, 32'hCAFEF00D, 0, 0, "both strobes");

        // Timeout: grant never comes
        never_gnt = 1;
        e = '{default: 0};
        e.kind = K_ERR;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        mem_re_i = 1'b1; addr_i = 32'h300; byte_sel_i = 2'b10; rd_waddr_i = 5'd9;
        hc = 0;
        @(negedge clk);
        while (hold_o && hc < 400) begin
            hc++;
            @(negedge clk);
        end
        check("timeout hold cycles", hc, TMO + 1);
        @(posedge clk);
        #2;
        mem_re_i = 1'b0;
        never_gnt = 0;

        // Reset while waiting for read data, then a late read-valid
        gnt_delay = 0; rv_delay = 4; rdata_v = 32'h87654321;
        e = '{default: 0};
        e.kind = K_BUS; e.we = 1'b0; e.addr = 32'h200; e.be = 4'hF; e.wdata = 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        mem_re_i = 1'b1; addr_i = 32'h200; byte_sel_i = 2'b10; rd_waddr_i = 5'd7; un_sign_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mem_re_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset in RWAIT");
        repeat (8) @(negedge clk);
        check_all_zero("after late rvalid");
        issue(1, 0, 32'h204, 32'd0, 2'b01, 0, 5'd7, 32'h0000F00D, 0, 0, "load after reset");

        // Randomized stimulus
        noise = 1;
        for (int i = 0; i < 80; i++) begin
            bit          re, we, uns;
            logic [1:0]  bs;
            logic [31:0] a;
            int          gd, rvd;
            re  = ($urandom_range(0, 9) < 5);
            we  = ($urandom_range(0, 9) < 5);
            uns = $urandom_range(0, 1);
            bs  = 2'($urandom_range(0, 3));
            a   = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (bs == 2'b01) a[0] = 1'b0;
                if (bs == 2'b10) a[1:0] = 2'b00;
            end
            if (re) begin
                gd  = $urandom_range(0, 1);
                rvd = (gd == 0) ? $urandom_range(0, 1) : 0;
            end else begin
                gd  = $urandom_range(0, 2);
                rvd = 0;
            end
            issue(re, we, a, $urandom, bs, uns, 5'($urandom_range(0, 31)), $urandom, gd, rvd, "random");
        end
        noise = 0;

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
